// File: rtl/obuf_pkg.sv
// obuf_pkg
// Shared definitions for the output-buffer controller: default geometry of the
// output-buffer RAM, the drain FSM state encoding and the skid buffer depth.
// Ports: none (package).

package obuf_pkg;

  localparam int DEF_VEC_WIDTH = 64;  // INT4 x 16
  localparam int DEF_ARR_DEPTH = 64;
  localparam int DEF_ADDR_W    = 6;   // log2(DEF_ARR_DEPTH)
  localparam int SKID_DEPTH    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } obuf_state_e;

endpackage

// File: rtl/obuf_ctrl_if.sv
// obuf_ctrl_if
// Drain stream port of the output-buffer controller (valid/ready).
// Signals:
//   rd_data  - streamed RAM word
//   rd_valid - stream valid
//   rd_last  - qualifies the final beat of a drain
//   rd_ready - downstream ready
// Modports: master (controller side), slave (consumer side).

interface obuf_ctrl_if
  import obuf_pkg::*;
#(
  parameter int VEC_WIDTH = DEF_VEC_WIDTH
);

  logic [VEC_WIDTH-1:0] rd_data;
  logic                 rd_valid;
  logic                 rd_last;
  logic                 rd_ready;

  modport master (
    output rd_data,
    output rd_valid,
    output rd_last,
    input  rd_ready
  );

  modport slave (
    input  rd_data,
    input  rd_valid,
    input  rd_last,
    output rd_ready
  );

endinterface

// File: rtl/obuf_skid.sv
// obuf_skid
// Two-entry FIFO that absorbs the one-cycle RAM read latency and downstream
// backpressure. Push and pop in the same cycle are legal and leave the count
// unchanged. The caller guarantees no push when full and no pop when empty.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   push, push_data - write a word at the tail
//   pop         - drop the head word
//   head        - current head word (storage cleared on reset)
//   count       - number of stored words (0..2)
//   empty       - count == 0

module obuf_skid
  import obuf_pkg::*;
#(
  parameter int WIDTH = DEF_VEC_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [SKID_DEPTH];
  logic             wr_idx;
  logic             rd_idx;
  logic [1:0]       count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      wr_idx  <= 1'b0;
      rd_idx  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_idx] <= push_data;
        wr_idx      <= ~wr_idx;
      end
      if (pop) begin
        rd_idx <= ~rd_idx;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = mem[rd_idx];
  assign count = count_q;
  assign empty = (count_q == 2'd0);

endmodule

// File: rtl/obuf_ctrl.sv
// obuf_ctrl
// Owns the single-port output-buffer RAM. PPU writes always take the port;
// a drain requester streams addresses 0..last out over a valid/ready port,
// issuing reads only in cycles the PPU leaves free. A 2-entry skid buffer
// holds read data while downstream stalls.
//
// Optional feature macro: OBUF_CTRL_STALL_CNT_EN
//   When defined, adds o_stall_cnt: a 16-bit saturating count of DRAIN cycles
//   in which a read had room to issue but lost the port to a PPU write.
//   Cleared on reset and on each accepted drain start.
//
// Ports:
//   i_clk, i_rst_n        - clock, synchronous active-low reset
//   i_ppu_we/addr/data    - PPU write request (never stalled)
//   i_drain_start         - one-cycle pulse, begin drain (ignored unless idle)
//   i_drain_last          - last address to drain (inclusive)
//   o_drain_busy          - high from accepted start until the done pulse
//   o_drain_done          - one-cycle pulse after the final beat handshakes
//   rd                    - drain stream (obuf_ctrl_if.master)
//   o_ram_we/addr/data    - RAM port
//   i_ram_q               - RAM read data, one cycle after the read address
//   o_stall_cnt           - (macro only) blocked-read cycle count
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for i_drain_start; last address latched on start
// DRAIN | issuing reads at rd_ptr whenever the port and skid room allow
// FLUSH | all reads issued; waiting for the last beat to handshake
// DONE  | one-cycle done pulse, then back to IDLE

module obuf_ctrl
  import obuf_pkg::*;
#(
  parameter int VEC_WIDTH = DEF_VEC_WIDTH,
  parameter int ARR_DEPTH = DEF_ARR_DEPTH,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_ppu_we,
  input  logic [ADDR_W-1:0]    i_ppu_addr,
  input  logic [VEC_WIDTH-1:0] i_ppu_data,
  input  logic                 i_drain_start,
  input  logic [ADDR_W-1:0]    i_drain_last,
  output logic                 o_drain_busy,
  output logic                 o_drain_done,
  obuf_ctrl_if.master          rd,
  output logic                 o_ram_we,
  output logic [ADDR_W-1:0]    o_ram_addr,
  output logic [VEC_WIDTH-1:0] o_ram_data,
  input  logic [VEC_WIDTH-1:0] i_ram_q
`ifdef OBUF_CTRL_STALL_CNT_EN
  ,
  output logic [15:0]          o_stall_cnt
`endif
);

  obuf_state_e state_q, state_d;

  logic [ADDR_W-1:0]    last_q;
  logic [ADDR_W-1:0]    rd_ptr_q;
  logic [ADDR_W-1:0]    emit_ptr_q;
  logic                 inflight_q;

  logic [VEC_WIDTH-1:0] skid_head;
  logic [1:0]           skid_count;
  logic                 skid_empty;

  logic                 pop;
  logic [2:0]           occupancy;
  logic                 read_want;
  logic                 rd_issue;
  logic                 last_issue;
  logic                 start_ok;

  // Stream side
  assign rd.rd_valid = ~skid_empty;
  assign rd.rd_data  = skid_head;
  assign rd.rd_last  = rd.rd_valid & (emit_ptr_q == last_q);
  assign pop         = rd.rd_valid & rd.rd_ready;

  // Words that will occupy the skid after this cycle if no read issues.
  // Crediting the same-cycle pop is what allows one beat per cycle with
  // only two entries; it can never overflow because a pop needs a word.
  assign occupancy  = {1'b0, skid_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign read_want  = (state_q == DRAIN) && (occupancy < 3'd2);
  assign rd_issue   = read_want & ~i_ppu_we;
  assign last_issue = rd_issue && (rd_ptr_q == last_q);
  assign start_ok   = (state_q == IDLE) & i_drain_start;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      last_q     <= '0;
      rd_ptr_q   <= '0;
      emit_ptr_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= rd_issue;
      if (start_ok) begin
        last_q     <= i_drain_last;
        rd_ptr_q   <= '0;
        emit_ptr_q <= '0;
      end else begin
        // Hold on the final issue so a full-depth drain never wraps.
        if (rd_issue && !last_issue) begin
          rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
          emit_ptr_q <= emit_ptr_q + ADDR_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    o_drain_busy = 1'b1;
    o_drain_done = 1'b0;
    case (state_q)
      IDLE: begin
        o_drain_busy = 1'b0;
        if (i_drain_start) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (last_issue) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (pop && rd.rd_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        o_drain_done = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // RAM port: PPU writes override any pending read.
  always_comb begin
    o_ram_we   = 1'b0;
    o_ram_addr = '0;
    o_ram_data = '0;
    if (i_ppu_we) begin
      o_ram_we   = 1'b1;
      o_ram_addr = i_ppu_addr;
      o_ram_data = i_ppu_data;
    end else if (rd_issue) begin
      o_ram_addr = rd_ptr_q;
    end
  end

  obuf_skid #(
    .WIDTH(VEC_WIDTH)
  ) u_skid (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (inflight_q),
    .push_data (i_ram_q),
    .pop       (pop),
    .head      (skid_head),
    .count     (skid_count),
    .empty     (skid_empty)
  );

`ifdef OBUF_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      stall_cnt_q <= '0;
    end else if (start_ok) begin
      stall_cnt_q <= '0;
    end else if (read_want && i_ppu_we && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_obuf_ctrl.sv
// tb_obuf_ctrl
// Self-checking bench for obuf_ctrl with a behavioural 64x64 RAM. Expected
// drain beats are pushed to a scoreboard queue when a drain is started and
// compared as the stream handshakes.

module tb_obuf_ctrl;
  import obuf_pkg::*;

  localparam int VW    = 64;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  typedef struct {
    logic [VW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ppu_we;
  logic [AW-1:0] ppu_addr;
  logic [VW-1:0] ppu_data;
  logic          drain_start;
  logic [AW-1:0] drain_last;
  logic          drain_busy;
  logic          drain_done;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [VW-1:0] ram_data;
  logic [VW-1:0] ram_q;
`ifdef OBUF_CTRL_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  obuf_ctrl_if #(.VEC_WIDTH(VW)) rd_if ();

  obuf_ctrl #(
    .VEC_WIDTH(VW),
    .ARR_DEPTH(DEPTH),
    .ADDR_W(AW)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_ppu_we      (ppu_we),
    .i_ppu_addr    (ppu_addr),
    .i_ppu_data    (ppu_data),
    .i_drain_start (drain_start),
    .i_drain_last  (drain_last),
    .o_drain_busy  (drain_busy),
    .o_drain_done  (drain_done),
    .rd            (rd_if),
    .o_ram_we      (ram_we),
    .o_ram_addr    (ram_addr),
    .o_ram_data    (ram_data),
    .i_ram_q       (ram_q)
`ifdef OBUF_CTRL_STALL_CNT_EN
    ,
    .o_stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM, registered read.
  logic [VW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_data;
    ram_q <= ram[ram_addr];
  end

  // Bench-side view of what the RAM should hold.
  logic [VW-1:0] exp_mem [DEPTH];

  beat_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_count = 0;
  int done_count = 0;
  int first_hs_cyc = -1;
  int last_hs_cyc = -1;
  int done_cyc = -1;
  bit prev_stall = 1'b0;
  logic [VW-1:0] prev_data;

  bit rdy_pattern = 1'b0;
  int phase = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Ready driver: either held high or the repeating 1,0,0,1 pattern.
  always @(posedge clk) begin
    #1;
    phase = phase + 1;
    if (rdy_pattern) rd_if.rd_ready = ((phase % 4) == 0) || ((phase % 4) == 3);
    else             rd_if.rd_ready = 1'b1;
  end

  // Stream monitor / scoreboard.
  always @(negedge clk) begin
    beat_t exp_b;
    if (rst_n === 1'b1) begin
      checks++;
      if (dut.skid_count > 2'd2) begin
        errors++;
        $display("FAIL skid_count: got %0d, limit 2", dut.skid_count);
      end
      if (prev_stall && rd_if.rd_valid) begin
        checks++;
        if (rd_if.rd_data !== prev_data) begin
          errors++;
          $display("FAIL stall_hold: got %h, expected %h", rd_if.rd_data, prev_data);
        end
      end
      prev_stall = rd_if.rd_valid && !rd_if.rd_ready;
      prev_data  = rd_if.rd_data;
      if (rd_if.rd_valid && rd_if.rd_ready) begin
        hs_count++;
        if (first_hs_cyc < 0) first_hs_cyc = cyc;
        if (rd_if.rd_last) last_hs_cyc = cyc;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: got %h, expected no beat", rd_if.rd_data);
        end else begin
          exp_b = sb.pop_front();
          if (rd_if.rd_data !== exp_b.data) begin
            errors++;
            $display("FAIL beat_data: got %h, expected %h", rd_if.rd_data, exp_b.data);
          end
          checks++;
          if (rd_if.rd_last !== exp_b.last) begin
            errors++;
            $display("FAIL beat_last: got %b, expected %b", rd_if.rd_last, exp_b.last);
          end
        end
      end
      if (drain_done === 1'b1) begin
        done_count++;
        done_cyc = cyc;
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_drain(input logic [AW-1:0] last);
    tick();
    drain_start = 1'b1;
    drain_last  = last;
    tick();
    drain_start = 1'b0;
  endtask

  task automatic push_expected(input int last);
    beat_t b;
    for (int k = 0; k <= last; k++) begin
      b.data = exp_mem[k];
      b.last = (k == last);
      sb.push_back(b);
    end
  endtask

  task automatic wait_done(input int max_cyc, output bit timed_out);
    int d0;
    d0 = done_count;
    timed_out = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if (done_count != d0) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [VW+VW+AW+4:0] obs;
    rst_n = 1'b0; ppu_we = 1'b0; ppu_addr = '0; ppu_data = '0;
    drain_start = 1'b0; drain_last = '0;
    for (int k = 0; k < DEPTH; k++) ram[k] = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge clk);
    obs = {drain_busy, drain_done, rd_if.rd_valid, rd_if.rd_last, ram_we,
           ram_addr, ram_data, rd_if.rd_data};
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, expected 0", obs);
    end
    checks++;
    if (dut.state_q !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d, expected %0d", dut.state_q, IDLE);
    end
  endtask

  task automatic test_preload();
    logic [3:0]    nib;
    logic [VW-1:0] word;
    for (int k = 0; k < DEPTH; k++) begin
      nib  = k[3:0];
      word = {16{nib}};
      exp_mem[k] = word;
      tick();
      ppu_we = 1'b1; ppu_addr = AW'(k); ppu_data = word;
      @(negedge clk);
      checks++;
      if ({ram_we, ram_addr, ram_data} !== {1'b1, AW'(k), word}) begin
        errors++;
        $display("FAIL preload_port: got %b/%0d/%h, expected 1/%0d/%h",
                 ram_we, ram_addr, ram_data, k, word);
      end
    end
    tick();
    ppu_we = 1'b0; ppu_data = '0;
    @(negedge clk);
    checks++;
    if ({ram_we, ram_data} !== '0) begin
      errors++;
      $display("FAIL idle_port: got we=%b data=%h, expected 0", ram_we, ram_data);
    end
  endtask

  task automatic run_and_check_drain(input string name, input int last, input int max_cyc);
    int h0, d0;
    bit to;
    h0 = hs_count; d0 = done_count; first_hs_cyc = -1;
    push_expected(last);
    start_drain(AW'(last));
    @(negedge clk);
    checks++;
    if (drain_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy: got %b, expected 1", name, drain_busy);
    end
    wait_done(max_cyc, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, max_cyc);
    end
    checks++;
    if (hs_count - h0 != last + 1) begin
      errors++;
      $display("FAIL %s_beats: got %0d, expected %0d", name, hs_count - h0, last + 1);
    end
    checks++;
    if (done_cyc != last_hs_cyc + 1) begin
      errors++;
      $display("FAIL %s_done_timing: got cycle %0d, expected %0d", name, done_cyc, last_hs_cyc + 1);
    end
    checks++;
    if (done_count - d0 != 1) begin
      errors++;
      $display("FAIL %s_done_count: got %0d, expected 1", name, done_count - d0);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_leftover: got %0d beats pending, expected 0", name, sb.size());
    end
  endtask

  task automatic test_full_drain();
    rdy_pattern = 1'b0;
    run_and_check_drain("full", 63, 400);
    checks++;
    if (last_hs_cyc - first_hs_cyc != 63) begin
      errors++;
      $display("FAIL full_gapless: got span %0d, expected 63", last_hs_cyc - first_hs_cyc);
    end
    checks++;
    if (drain_busy !== 1'b0) begin
      errors++;
      $display("FAIL full_busy_after: got %b, expected 0", drain_busy);
    end
  endtask

  task automatic test_single();
    rdy_pattern = 1'b0;
    run_and_check_drain("single", 0, 50);
  endtask

  task automatic test_backpressure();
    rdy_pattern = 1'b1;
    run_and_check_drain("bp", 15, 300);
    rdy_pattern = 1'b0;
  endtask

  task automatic test_ppu_collision();
    int h0, d0;
    bit to;
    rdy_pattern = 1'b0;
    exp_mem[40] = 64'hA5;
    h0 = hs_count; d0 = done_count;
    push_expected(63);
    start_drain(AW'(63));
    to = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (hs_count - h0 >= 5) begin
        to = 1'b0;
        break;
      end
    end
    checks++;
    if (to) begin
      errors++;
      $display("FAIL coll_first_beats: got %0d beats, expected 5", hs_count - h0);
    end
    for (int i = 0; i < 5; i++) begin
      ppu_we = 1'b1; ppu_addr = AW'(40); ppu_data = 64'hA5;
      @(negedge clk);
      checks++;
      if ({ram_we, ram_addr, ram_data, dut.rd_issue} !== {1'b1, AW'(40), 64'hA5, 1'b0}) begin
        errors++;
        $display("FAIL coll_port: got we=%b addr=%0d data=%h issue=%b, expected 1/40/a5/0",
                 ram_we, ram_addr, ram_data, dut.rd_issue);
      end
      tick();
    end
    ppu_we = 1'b0; ppu_data = '0;
    wait_done(400, to);
    checks++;
    if (to || (hs_count - h0 != 64) || (done_count - d0 != 1)) begin
      errors++;
      $display("FAIL coll_drain: got beats=%0d dones=%0d timeout=%b, expected 64/1/0",
               hs_count - h0, done_count - d0, to);
    end
`ifdef OBUF_CTRL_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd5) begin
      errors++;
      $display("FAIL coll_stall_cnt: got %0d, expected 5", stall_cnt);
    end
`endif
  endtask

  task automatic test_restart_ignored();
    int h0, d0;
    bit to;
    rdy_pattern = 1'b0;
    h0 = hs_count; d0 = done_count;
    push_expected(15);
    start_drain(AW'(15));
    tick(); tick();
    drain_start = 1'b1; drain_last = AW'(3);
    tick();
    drain_start = 1'b0;
    wait_done(200, to);
    repeat (5) tick();
    checks++;
    if (to || (hs_count - h0 != 16)) begin
      errors++;
      $display("FAIL restart_beats: got %0d timeout=%b, expected 16/0", hs_count - h0, to);
    end
    checks++;
    if (done_count - d0 != 1) begin
      errors++;
      $display("FAIL restart_dones: got %0d, expected 1", done_count - d0);
    end
  endtask

  task automatic test_reset_mid();
    logic [VW+VW+AW+4:0] obs;
    int h0, d0;
    bit to;
    rdy_pattern = 1'b0;
    h0 = hs_count;
    push_expected(63);
    start_drain(AW'(63));
    to = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (hs_count - h0 >= 10) begin
        to = 1'b0;
        break;
      end
    end
    checks++;
    if (to) begin
      errors++;
      $display("FAIL rstmid_beats: got %0d, expected 10", hs_count - h0);
    end
    rst_n = 1'b0;
    d0 = done_count;
    sb.delete();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    obs = {drain_busy, drain_done, rd_if.rd_valid, rd_if.rd_last, ram_we,
           ram_addr, ram_data, rd_if.rd_data};
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: got %h, expected 0", obs);
    end
    checks++;
    if (dut.state_q !== IDLE) begin
      errors++;
      $display("FAIL rstmid_state: got %0d, expected %0d", dut.state_q, IDLE);
    end
    repeat (5) tick();
    checks++;
    if (done_count != d0) begin
      errors++;
      $display("FAIL rstmid_no_done: got %0d pulses, expected 0", done_count - d0);
    end
    run_and_check_drain("fresh", 7, 100);
  endtask

  initial begin
    test_reset();
    test_preload();
    test_full_drain();
    test_single();
    test_backpressure();
    test_ppu_collision();
    test_restart_ignored();
    test_reset_mid();
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
